alu_operand_skid: RTL and testbench
===================================

# alu_operand_skid

Two-entry registered skid buffer that sits directly upstream of the ALU datapath (and/or/add/shift units). It accepts a decoded ALU operation (opcode, shift amount, operands A and B, destination tag) from the decode/bypass stage and presents it to the ALU with a valid/ready handshake. It sustains full throughput and has no combinational path from ALU-side ready back to decode-side ready. It also supports a pipeline flush and counts issued operations for performance monitoring.

## Interface
- DATA_W, 32, operand width (A, B)
- TAG_W, 5, destination-register tag width
- CNT_W, 16, width of the issued-operation counter

- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- flush  in  1  discard all buffered entries and the current input
- in_valid  in  1  upstream has an operation
- in_ready  out  1  buffer can accept; equals (state != FULL)
- in_op  in  5  ALU opcode
- in_shamt  in  5  shift amount
- in_A  in  DATA_W  operand A
- in_B  in  DATA_W  operand B
- in_tag  in  TAG_W  destination tag
- out_valid  out  1  main entry holds an operation
- out_ready  in  1  ALU stage consumes this cycle
- out_op, out_shamt, out_A, out_B, out_tag  out  5/5/DATA_W/DATA_W/TAG_W  main entry fields, driven directly from flops
- occupancy  out  2  entries held: 0, 1 or 2
- issued_count  out  CNT_W  number of completed output handshakes, wraps modulo 2^CNT_W

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: main entry drives out_*; skid entry is used only in FULL.
- States: EMPTY (occupancy 0), ONE (1), FULL (2). out_valid = (state != EMPTY).
- EMPTY: push -> ONE, main <= in.
- ONE: push & pop -> ONE, main <= in. push & !pop -> FULL, skid <= in. pop & !push -> EMPTY. Neither -> hold.
- FULL: in_ready = 0, so no push. pop -> ONE, main <= skid. Otherwise hold.
- Ordering is strict FIFO. No entry is duplicated or dropped, except on flush.
- flush (reset high) takes priority over everything:
  - next state is EMPTY;
  - a push in the same cycle is discarded;
  - a pop in the same cycle still counts toward issued_count, because the ALU has already taken it.
- issued_count increments by 1 on every pop. It wraps from 2^CNT_W-1 to 0. flush does not clear it.
- Data fields are unchanged when not loaded. After the buffer drains to EMPTY, out_* keep their last value, with out_valid 0.
- The buffer never inspects in_op or the operands. Width is preserved bit-exactly.

## Timing
- Reset (reset=0 at an edge): state EMPTY, out_valid 0, occupancy 0, issued_count 0, all out_* data fields 0, skid cleared to 0.
- Inputs sampled in a reset cycle are ignored.
- in_ready is 1 after reset, including during reset cycles, because it is a decode of state only.
- Latency: an input accepted at edge N appears on out_* with out_valid=1 after edge N. One cycle, not zero.
- Throughput: one operation per cycle when out_ready is held high. FULL is reached only when out_ready drops.
- in_ready depends only on registered state. There is no combinational path from out_ready or in_valid to in_ready.
- out_valid must not drop while out_ready is low. out_* data must be stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation discards all entries on that edge. It behaves like flush, except that it also clears issued_count and the data fields.

## Test plan
- Reset then stream: reset low 2 cycles, then push A=0x0000_00F0/B=0x0000_0F0F with op 00011 and tag 5, out_ready=1 -> next cycle out_valid=1, out_A=0x0000_00F0, out_B=0x0000_0F0F, out_tag=5; issued_count=1 after the pop.
- Back-pressure: out_ready=0, push 3 operations in consecutive cycles (A=1,2,3) -> in_ready drops after the 2nd, occupancy=2, the 3rd is held upstream. Then out_ready=1 -> outputs A=1,2,3 in order, with no bubble after the first pop.
- Full throughput: 100 back-to-back pushes with out_ready=1 -> out_valid continuously 1 from cycle 1, occupancy never exceeds 1, issued_count=100.
- Flush in FULL with simultaneous in_valid: occupancy=2, assert flush and in_valid (A=0xDEAD_BEEF) -> next cycle out_valid=0, occupancy=0, and 0xDEAD_BEEF never appears on the output.
- Counter wrap: CNT_W=4, perform 17 pops -> issued_count=1; flush in between leaves the count unchanged.
- Reset mid-operation: occupancy=2, then reset low for one edge -> out_valid=0, out_A=0, issued_count=0, in_ready=1.

Source files
------------

// File: rtl/alu_operand_skid.sv
`default_nettype none
// ============================================================================
//  Module   : alu_operand_skid
//  Purpose  : Two-entry registered skid buffer in front of the ALU datapath.
//             Carries a decoded ALU operation (opcode, shift amount, operands
//             A/B, destination tag) from decode/bypass to the ALU with a
//             valid/ready handshake. It sustains one operation per cycle, and
//             in_ready_o is a pure decode of registered state. The block also
//             supports a pipeline flush and keeps a wrapping count of issued
//             operations.
//  Ports    : clock_i       - sole clock, rising edge
//             reset_i       - synchronous reset, active low
//             flush_i       - drop buffered entries and the current input
//             in_valid_i / in_ready_o           - upstream handshake
//             in_op_i, in_shamt_i, in_A_i, in_B_i, in_tag_i - operation in
//             out_valid_o / out_ready_i         - ALU-side handshake
//             out_op_o, out_shamt_o, out_A_o, out_B_o, out_tag_o - main entry
//             occupancy_o   - entries held (0..2)
//             issued_count_o- completed output handshakes, modulo 2^CNT_W
//  Revision : 1.0 - initial release
// ============================================================================
module alu_operand_skid #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [4:0]        in_op_i,
    input  logic [4:0]        in_shamt_i,
    input  logic [DATA_W-1:0] in_A_i,
    input  logic [DATA_W-1:0] in_B_i,
    input  logic [TAG_W-1:0]  in_tag_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [4:0]        out_op_o,
    output logic [4:0]        out_shamt_o,
    output logic [DATA_W-1:0] out_A_o,
    output logic [DATA_W-1:0] out_B_o,
    output logic [TAG_W-1:0]  out_tag_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  issued_count_o
);

    localparam int ENTRY_W = 5 + 5 + DATA_W + DATA_W + TAG_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [1:0]         occupancy_q;
    logic [CNT_W-1:0]   count_q;
    logic [ENTRY_W-1:0] main_q;
    logic [ENTRY_W-1:0] skid_q;

    logic               push;
    logic               pop;
    logic               load_main_in;
    logic               load_main_skid;
    logic               load_skid;
    logic [ENTRY_W-1:0] in_entry;

    assign in_entry = {in_op_i, in_shamt_i, in_A_i, in_B_i, in_tag_i};

    // in_ready_q is registered alongside the state, so ALU-side ready has
    // no combinational route back to the decode stage.
    assign push = in_valid_i & in_ready_q;
    assign pop  = out_valid_q & out_ready_i;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_i) begin
            // A pop in this cycle is still counted; a push is discarded.
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        state_d      = S_ONE;
                        load_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        load_main_in = 1'b1;
                    end else if (push) begin
                        state_d   = S_FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        state_d        = S_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
            count_q     <= '0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != S_FULL);
            out_valid_q <= (state_d != S_EMPTY);
            case (state_d)
                S_ONE:   occupancy_q <= 2'd1;
                S_FULL:  occupancy_q <= 2'd2;
                default: occupancy_q <= 2'd0;
            endcase
            if (pop) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (load_main_in) begin
                main_q <= in_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    assign in_ready_o     = in_ready_q;
    assign out_valid_o    = out_valid_q;
    assign occupancy_o    = occupancy_q;
    assign issued_count_o = count_q;
    assign {out_op_o, out_shamt_o, out_A_o, out_B_o, out_tag_o} = main_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_skid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_operand_skid
//  Purpose  : Self-checking bench for alu_operand_skid. A queue-based model
//             of the buffer predicts every output after each clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_skid;

    localparam int DW = 32;
    localparam int TW = 5;
    localparam int CW = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [4:0]    in_op     = '0;
    logic [4:0]    in_shamt  = '0;
    logic [DW-1:0] in_A      = '0;
    logic [DW-1:0] in_B      = '0;
    logic [TW-1:0] in_tag    = '0;

    logic          in_ready;
    logic          out_valid;
    logic [4:0]    out_op;
    logic [4:0]    out_shamt;
    logic [DW-1:0] out_A;
    logic [DW-1:0] out_B;
    logic [TW-1:0] out_tag;
    logic [1:0]    occupancy;
    logic [CW-1:0] issued_count;

    alu_operand_skid #(.DATA_W(DW), .TAG_W(TW), .CNT_W(CW)) dut (
        .clock_i        (clk),
        .reset_i        (rst_n),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_op_i        (in_op),
        .in_shamt_i     (in_shamt),
        .in_A_i         (in_A),
        .in_B_i         (in_B),
        .in_tag_i       (in_tag),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_op_o       (out_op),
        .out_shamt_o    (out_shamt),
        .out_A_o        (out_A),
        .out_B_o        (out_B),
        .out_tag_o      (out_tag),
        .occupancy_o    (occupancy),
        .issued_count_o (issued_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]    op;
        logic [4:0]    sh;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [TW-1:0] tag;
    } ent_t;

    ent_t        mq[$];
    ent_t        held = '0;
    int unsigned m_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    bit          seen_dead = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        ent_t e;
        e = (mq.size() > 0) ? mq[0] : held;
        chk("in_ready",  64'(in_ready),     64'(mq.size() < 2));
        chk("out_valid", 64'(out_valid),    64'(mq.size() > 0));
        chk("occupancy", 64'(occupancy),    64'(mq.size()));
        chk("count",     64'(issued_count), 64'(m_cnt % 16));
        chk("out_op",    64'(out_op),       64'(e.op));
        chk("out_shamt", 64'(out_shamt),    64'(e.sh));
        chk("out_A",     64'(out_A),        64'(e.a));
        chk("out_B",     64'(out_B),        64'(e.b));
        chk("out_tag",   64'(out_tag),      64'(e.tag));
        if (out_A === 32'hDEAD_BEEF) seen_dead = 1'b1;
    endtask

    // One clock: model the edge from the inputs currently applied, then
    // compare every output on the following falling edge.
    task automatic tick();
        bit   push;
        bit   pop;
        ent_t pre_head;
        ent_t ine;
        push     = in_valid && (mq.size() < 2);
        pop      = out_ready && (mq.size() > 0);
        pre_head = (mq.size() > 0) ? mq[0] : held;
        ine      = '{op: in_op, sh: in_shamt, a: in_A, b: in_B, tag: in_tag};
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_cnt = 0;
            held  = '0;
        end else begin
            if (pop) begin
                m_cnt++;
                void'(mq.pop_front());
            end
            if (flush) mq.delete();
            else if (push) mq.push_back(ine);
            held = (mq.size() > 0) ? mq[0] : pre_head;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [4:0] op, input logic [TW-1:0] tag);
        in_valid = v;
        in_A     = a;
        in_B     = b;
        in_op    = op;
        in_shamt = 5'($urandom);
        in_tag   = tag;
    endtask

    task automatic drive_rand(input logic v);
        drive(v, $urandom, $urandom, 5'($urandom), TW'($urandom));
    endtask

    initial begin
        int base;
        @(negedge clk);

        // Reset for two edges with junk on the inputs.
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive_rand(1'b1);
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_A", 64'(out_A), 64'd0);
        rst_n = 1'b1;

        // Single operation streamed through.
        drive(1'b1, 32'h0000_00F0, 32'h0000_0F0F, 5'b00011, 5'd5);
        tick();
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_A", 64'(out_A), 64'h0000_00F0);
        chk("stream_B", 64'(out_B), 64'h0000_0F0F);
        chk("stream_tag", 64'(out_tag), 64'd5);
        drive(1'b0, 0, 0, 0, 0);
        tick();
        chk("stream_count", 64'(issued_count), 64'd1);

        // Back-pressure: three pushes, third held upstream.
        out_ready = 1'b0;
        drive(1'b1, 1, 11, 5'd1, 5'd1);
        tick();
        drive(1'b1, 2, 12, 5'd2, 5'd2);
        tick();
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_occ", 64'(occupancy), 64'd2);
        drive(1'b1, 3, 13, 5'd3, 5'd3);
        tick();
        chk("bp_hold_A", 64'(out_A), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_A2", 64'(out_A), 64'd2);
        tick();
        chk("bp_A3", 64'(out_A), 64'd3);
        drive(1'b0, 0, 0, 0, 0);
        tick();

        // Full throughput: 100 back-to-back operations.
        base = int'(m_cnt);
        for (int i = 0; i < 100; i++) begin
            drive_rand(1'b1);
            tick();
            chk("tput_occ_le1", 64'(occupancy <= 2'd1), 64'd1);
        end
        drive(1'b0, 0, 0, 0, 0);
        tick();
        chk("tput_count", 64'(issued_count), 64'((base + 100) % 16));

        // Flush while FULL with a simultaneous push of 0xDEADBEEF.
        out_ready = 1'b0;
        drive_rand(1'b1);
        tick();
        drive_rand(1'b1);
        tick();
        chk("fl_occ2", 64'(occupancy), 64'd2);
        flush = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, 0, 0, 0);
        tick();
        flush = 1'b0;
        drive(1'b0, 0, 0, 0, 0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_occ", 64'(occupancy), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("fl_no_dead", 64'(seen_dead), 64'd0);

        // Counter wrap: 17 pops from reset, with a flush in between.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive_rand(1'b1);
            tick();
        end
        drive(1'b0, 0, 0, 0, 0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("wrap_flush_keep", 64'(issued_count), 64'd9);
        for (int i = 0; i < 8; i++) begin
            drive_rand(1'b1);
            tick();
        end
        drive(1'b0, 0, 0, 0, 0);
        tick();
        chk("wrap_count", 64'(issued_count), 64'd1);

        // Reset mid-operation with two entries held.
        out_ready = 1'b0;
        drive_rand(1'b1);
        tick();
        drive_rand(1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b0, 0, 0, 0, 0);
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_A", 64'(out_A), 64'd0);
        chk("mrst_count", 64'(issued_count), 64'd0);
        chk("mrst_ready", 64'(in_ready), 64'd1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 500; i++) begin
            drive_rand(1'(($urandom % 4) != 0));
            out_ready = 1'(($urandom % 3) != 0);
            flush     = 1'(($urandom % 16) == 0);
            rst_n     = 1'(($urandom % 64) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
